// File: rtl/ddr3_avl_pkg.sv
// rtl/ddr3_avl_pkg.sv - shared Avalon widths, scalar width and read FSM state type
package ddr3_avl_pkg;

    localparam int AVL_ADDR_W = 26;
    localparam int AVL_DATA_W = 128;
    localparam int SCALAR_W   = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2
    } rd_state_e;

endpackage

// File: rtl/read_from_ddr3_if.sv
// rtl/read_from_ddr3_if.sv - Avalon-MM read command/data bundle between reader and DDR3 controller
interface read_from_ddr3_if;
    import ddr3_avl_pkg::*;

    logic                  ddr3_avl_ready;
    logic [AVL_DATA_W-1:0] ddr3_avl_rdata;
    logic                  ddr3_avl_rdata_valid;
    logic                  ddr3_avl_burstbegin;
    logic                  ddr3_avl_read_req;
    logic [2:0]            ddr3_avl_size;
    logic [AVL_ADDR_W-1:0] ddr3_avl_addr;

    modport master (
        input  ddr3_avl_ready, ddr3_avl_rdata, ddr3_avl_rdata_valid,
        output ddr3_avl_burstbegin, ddr3_avl_read_req, ddr3_avl_size, ddr3_avl_addr
    );

    modport slave (
        output ddr3_avl_ready, ddr3_avl_rdata, ddr3_avl_rdata_valid,
        input  ddr3_avl_burstbegin, ddr3_avl_read_req, ddr3_avl_size, ddr3_avl_addr
    );

endinterface

// File: rtl/ddr3_rd_watchdog.sv
// rtl/ddr3_rd_watchdog.sv - stall counter that flags a read burst making no progress
module ddr3_rd_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    // Count idle-progress cycles; any command/beat or return to IDLE restarts the window
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (run_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = run_i && !clear_i && (count_q == LIMIT);

endmodule

// File: rtl/read_from_ddr3.sv
// rtl/read_from_ddr3.sv - single-burst DDR3 Avalon reader; optional watchdog under READ_FROM_DDR3_TIMEOUT_EN
module read_from_ddr3
    import ddr3_avl_pkg::*;
#(
    parameter int BURST_LEN      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  ddr3_clk,
    input  logic                  reset_n,
    input  logic [31:0]           test_addr,
    input  logic                  test_rd,
    output logic                  test_busy,
    output logic [SCALAR_W-1:0]   test_rd_data,
    output logic                  test_rd_done,
    output logic                  test_rd_err,
    output logic [AVL_DATA_W-1:0] rd_beat_data,
    output logic                  rd_beat_valid,
    output logic                  rd_beat_last,
    read_from_ddr3_if.master      avl
);

    localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

    rd_state_e             state_q, state_d;
    logic [AVL_ADDR_W-1:0] addr_q, addr_d;
    logic                  read_req_q, read_req_d;
    logic                  burstbegin_q, burstbegin_d;
    logic [2:0]            beat_cnt_q, beat_cnt_d;
    logic [SCALAR_W-1:0]   rd_data_q, rd_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [AVL_DATA_W-1:0] beat_data_q, beat_data_d;
    logic                  beat_valid_q, beat_valid_d;
    logic                  beat_last_q, beat_last_d;
    logic                  timeout;

    logic unused_addr_hi;
    assign unused_addr_hi = ^test_addr[31:AVL_ADDR_W];

`ifdef READ_FROM_DDR3_TIMEOUT_EN
    logic wd_clear;

    // Restart the stall window in IDLE and whenever the controller makes progress
    assign wd_clear = (state_q == IDLE)
                   || (state_q == REQ && avl.ddr3_avl_ready)
                   || (state_q == WAIT_DATA && avl.ddr3_avl_rdata_valid);

    ddr3_rd_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (ddr3_clk),
        .rst_n     (reset_n),
        .clear_i   (wd_clear),
        .run_i     (state_q != IDLE),
        .expired_o (timeout)
    );
`else
    localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Next-state and registered-output logic for the IDLE -> REQ -> WAIT_DATA burst sequence
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        read_req_d   = read_req_q;
        burstbegin_d = burstbegin_q;
        beat_cnt_d   = beat_cnt_q;
        rd_data_d    = rd_data_q;
        beat_data_d  = beat_data_q;
        beat_valid_d = 1'b0;
        beat_last_d  = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (test_rd) begin
                    addr_d       = test_addr[AVL_ADDR_W-1:0];
                    read_req_d   = 1'b1;
                    burstbegin_d = 1'b1;
                    beat_cnt_d   = '0;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (timeout) begin
                    read_req_d   = 1'b0;
                    burstbegin_d = 1'b0;
                    err_d        = 1'b1;
                    state_d      = IDLE;
                end else if (avl.ddr3_avl_ready) begin
                    read_req_d   = 1'b0;
                    burstbegin_d = 1'b0;
                    state_d      = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (avl.ddr3_avl_rdata_valid) begin
                    beat_data_d  = avl.ddr3_avl_rdata;
                    beat_valid_d = 1'b1;
                    beat_cnt_d   = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == 3'd0) begin
                        rd_data_d = avl.ddr3_avl_rdata[SCALAR_W-1:0];
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_last_d = 1'b1;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge ddr3_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            read_req_q   <= 1'b0;
            burstbegin_q <= 1'b0;
            beat_cnt_q   <= '0;
            rd_data_q    <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            beat_data_q  <= '0;
            beat_valid_q <= 1'b0;
            beat_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            read_req_q   <= read_req_d;
            burstbegin_q <= burstbegin_d;
            beat_cnt_q   <= beat_cnt_d;
            rd_data_q    <= rd_data_d;
            done_q       <= done_d;
            err_q        <= err_d;
            beat_data_q  <= beat_data_d;
            beat_valid_q <= beat_valid_d;
            beat_last_q  <= beat_last_d;
        end
    end

    assign test_busy               = (state_q != IDLE);
    assign test_rd_data            = rd_data_q;
    assign test_rd_done            = done_q;
    assign test_rd_err             = err_q;
    assign rd_beat_data            = beat_data_q;
    assign rd_beat_valid           = beat_valid_q;
    assign rd_beat_last            = beat_last_q;
    assign avl.ddr3_avl_addr       = addr_q;
    assign avl.ddr3_avl_read_req   = read_req_q;
    assign avl.ddr3_avl_burstbegin = burstbegin_q;
    assign avl.ddr3_avl_size       = 3'(BURST_LEN);

endmodule

// File: tb/tb_read_from_ddr3.sv
// tb/tb_read_from_ddr3.sv - scoreboard bench for read_from_ddr3; timeout scenario under READ_FROM_DDR3_TIMEOUT_EN
module tb_read_from_ddr3;

    localparam int BL = 4;
    localparam int TO = 16;

    logic         clk;
    logic         reset_n;
    logic [31:0]  test_addr;
    logic         test_rd;
    logic         test_busy;
    logic [31:0]  test_rd_data;
    logic         test_rd_done;
    logic         test_rd_err;
    logic [127:0] rd_beat_data;
    logic         rd_beat_valid;
    logic         rd_beat_last;

    read_from_ddr3_if avl ();

    read_from_ddr3 #(
        .BURST_LEN      (BL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ddr3_clk      (clk),
        .reset_n       (reset_n),
        .test_addr     (test_addr),
        .test_rd       (test_rd),
        .test_busy     (test_busy),
        .test_rd_data  (test_rd_data),
        .test_rd_done  (test_rd_done),
        .test_rd_err   (test_rd_err),
        .rd_beat_data  (rd_beat_data),
        .rd_beat_valid (rd_beat_valid),
        .rd_beat_last  (rd_beat_last),
        .avl           (avl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int beat_cnt = 0;
    int done_cnt = 0;
    int req_cycles = 0;
    int accept_cnt = 0;
    int err_cnt = 0;

    logic [127:0] exp_data_q[$];
    bit           exp_last_q[$];

    // Scoreboard: every beat pulse must match the oldest beat driven into the controller side
    always @(negedge clk) begin
        logic [127:0] ed;
        bit el;
        if (rd_beat_valid) begin
            beat_cnt++;
            if (exp_data_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_beat: rd_beat_valid=1 data=%h, required no beat", rd_beat_data);
            end else begin
                ed = exp_data_q.pop_front();
                el = exp_last_q.pop_front();
                total++;
                if (rd_beat_data !== ed) $display("FAIL beat_data: got %h required %h", rd_beat_data, ed);
                else passed++;
                total++;
                if (rd_beat_last !== el) $display("FAIL beat_last: got %b required %b", rd_beat_last, el);
                else passed++;
            end
        end
        if (test_rd_done) done_cnt++;
        if (test_rd_err) err_cnt++;
        if (avl.ddr3_avl_read_req) req_cycles++;
        if (avl.ddr3_avl_read_req && avl.ddr3_avl_ready) accept_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_read(input logic [31:0] addr, input int stall, input int gap,
                           input logic [31:0] base, input bit poke);
        logic [25:0]  ea;
        logic [127:0] d;
        int rq0, ac0, bc0, dc0;
        ea  = addr[25:0];
        rq0 = req_cycles;
        ac0 = accept_cnt;
        bc0 = beat_cnt;
        dc0 = done_cnt;
        test_addr = addr;
        test_rd   = 1'b1;
        avl.ddr3_avl_ready = (stall == 0);
        tick;
        test_rd = 1'b0;
        total++;
        if ({avl.ddr3_avl_read_req, avl.ddr3_avl_burstbegin, test_busy} !== 3'b111)
            $display("FAIL req_start: req/bb/busy=%b required 111", {avl.ddr3_avl_read_req, avl.ddr3_avl_burstbegin, test_busy});
        else passed++;
        total++;
        if (avl.ddr3_avl_addr !== ea) $display("FAIL avl_addr: got %h required %h", avl.ddr3_avl_addr, ea);
        else passed++;
        for (int s = 0; s < stall; s++) begin
            tick;
            total++;
            if ({avl.ddr3_avl_read_req, avl.ddr3_avl_burstbegin, avl.ddr3_avl_addr} !== {2'b11, ea})
                $display("FAIL req_hold: req/bb/addr=%b/%b/%h required 1/1/%h", avl.ddr3_avl_read_req, avl.ddr3_avl_burstbegin, avl.ddr3_avl_addr, ea);
            else passed++;
        end
        avl.ddr3_avl_ready = 1'b1;
        tick;
        total++;
        if ({avl.ddr3_avl_read_req, avl.ddr3_avl_burstbegin} !== 2'b00)
            $display("FAIL req_drop: req/bb=%b required 00", {avl.ddr3_avl_read_req, avl.ddr3_avl_burstbegin});
        else passed++;
        for (int b = 0; b < BL; b++) begin
            for (int g = 0; g < gap; g++) begin
                avl.ddr3_avl_rdata_valid = 1'b0;
                tick;
                total++;
                if ({test_busy, test_rd_done} !== 2'b10)
                    $display("FAIL gap_state: busy/done=%b required 10", {test_busy, test_rd_done});
                else passed++;
            end
            d = {$urandom, $urandom, $urandom, base + 32'(b)};
            avl.ddr3_avl_rdata = d;
            avl.ddr3_avl_rdata_valid = 1'b1;
            if (poke) begin
                test_rd   = 1'b1;
                test_addr = addr ^ 32'h00FF_0000;
            end
            exp_data_q.push_back(d);
            exp_last_q.push_back(b == BL - 1);
            tick;
            avl.ddr3_avl_rdata_valid = 1'b0;
            test_rd = 1'b0;
        end
        total++;
        if ({test_rd_done, rd_beat_last, rd_beat_valid, test_busy} !== 4'b1110)
            $display("FAIL done_latency: done/last/valid/busy=%b required 1110", {test_rd_done, rd_beat_last, rd_beat_valid, test_busy});
        else passed++;
        tick;
        total++;
        if (test_rd_done !== 1'b0) $display("FAIL done_pulse: done=%b required 0", test_rd_done);
        else passed++;
        total++;
        if (test_rd_data !== base) $display("FAIL rd_data: got %h required %h", test_rd_data, base);
        else passed++;
        total++;
        if ({beat_cnt - bc0, done_cnt - dc0, req_cycles - rq0, accept_cnt - ac0} !== {BL, 1, stall + 1, 1})
            $display("FAIL burst_counts: beats/done/req/acc=%0d/%0d/%0d/%0d required %0d/1/%0d/1",
                     beat_cnt - bc0, done_cnt - dc0, req_cycles - rq0, accept_cnt - ac0, BL, stall + 1);
        else passed++;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        test_addr = 32'h0;
        test_rd = 1'b0;
        avl.ddr3_avl_ready = 1'b0;
        avl.ddr3_avl_rdata = '0;
        avl.ddr3_avl_rdata_valid = 1'b0;
        repeat (3) tick;
        total++;
        if ({test_busy, test_rd_done, test_rd_err, rd_beat_valid, rd_beat_last,
             avl.ddr3_avl_read_req, avl.ddr3_avl_burstbegin} !== 7'b0)
            $display("FAIL reset_flags: got %b required 0000000", {test_busy, test_rd_done, test_rd_err, rd_beat_valid,
                     rd_beat_last, avl.ddr3_avl_read_req, avl.ddr3_avl_burstbegin});
        else passed++;
        total++;
        if ({test_rd_data, rd_beat_data, avl.ddr3_avl_addr} !== '0)
            $display("FAIL reset_data: data=%h beat=%h addr=%h required 0", test_rd_data, rd_beat_data, avl.ddr3_avl_addr);
        else passed++;
        total++;
        if (avl.ddr3_avl_size !== 3'd4) $display("FAIL avl_size: got %0d required 4", avl.ddr3_avl_size);
        else passed++;
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        do_read(32'h0000_1234, 0, 0, 32'h0000_00A0, 1'b0);
    endtask

    task automatic test_backpressure;
        do_read(32'hFC00_5678, 5, 0, 32'h0000_0B00, 1'b0);
    endtask

    task automatic test_gapped;
        do_read(32'h0100_0040, 0, 3, 32'h0000_00B0, 1'b0);
    endtask

    task automatic test_busy_stray;
        int rq0;
        do_read(32'h0000_0ABC, 0, 1, 32'h0000_00C0, 1'b1);
        rq0 = req_cycles;
        for (int i = 0; i < 3; i++) begin
            avl.ddr3_avl_rdata = {$urandom, $urandom, $urandom, $urandom};
            avl.ddr3_avl_rdata_valid = 1'b1;
            tick;
            total++;
            if ({rd_beat_valid, test_busy} !== 2'b00)
                $display("FAIL stray_idle: valid/busy=%b required 00", {rd_beat_valid, test_busy});
            else passed++;
        end
        avl.ddr3_avl_rdata_valid = 1'b0;
        tick;
        total++;
        if (req_cycles !== rq0) $display("FAIL no_queued_req: req cycles %0d required %0d", req_cycles, rq0);
        else passed++;
        do_read(32'h0222_3344, 0, 0, 32'h0000_00D0, 1'b0);
    endtask

    task automatic test_reset_mid;
        logic [127:0] d;
        test_addr = 32'h0001_0F00;
        test_rd = 1'b1;
        avl.ddr3_avl_ready = 1'b1;
        tick;
        test_rd = 1'b0;
        tick;
        for (int b = 0; b < 2; b++) begin
            d = {$urandom, $urandom, $urandom, 32'h0000_00E0 + 32'(b)};
            avl.ddr3_avl_rdata = d;
            avl.ddr3_avl_rdata_valid = 1'b1;
            exp_data_q.push_back(d);
            exp_last_q.push_back(1'b0);
            tick;
        end
        avl.ddr3_avl_rdata_valid = 1'b0;
        tick;
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if ({test_busy, test_rd_done, rd_beat_valid, rd_beat_last, avl.ddr3_avl_read_req} !== 5'b0)
            $display("FAIL async_reset_flags: got %b required 00000",
                     {test_busy, test_rd_done, rd_beat_valid, rd_beat_last, avl.ddr3_avl_read_req});
        else passed++;
        total++;
        if ({test_rd_data, rd_beat_data, avl.ddr3_avl_addr} !== '0)
            $display("FAIL async_reset_data: data=%h beat=%h addr=%h required 0", test_rd_data, rd_beat_data, avl.ddr3_avl_addr);
        else passed++;
        avl.ddr3_avl_rdata_valid = 1'b1;
        tick;
        tick;
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick;
            total++;
            if ({rd_beat_valid, test_busy} !== 2'b00)
                $display("FAIL late_beat: valid/busy=%b required 00", {rd_beat_valid, test_busy});
            else passed++;
        end
        avl.ddr3_avl_rdata_valid = 1'b0;
        tick;
        do_read(32'h0333_0010, 0, 0, 32'h0000_00F0, 1'b0);
    endtask

`ifdef READ_FROM_DDR3_TIMEOUT_EN
    task automatic test_timeout;
        logic [31:0] prev;
        int dc0, k;
        prev = 32'h0000_00F0;
        dc0  = done_cnt;
        k    = -1;
        test_addr = 32'h0000_7777;
        test_rd = 1'b1;
        avl.ddr3_avl_ready = 1'b0;
        tick;
        test_rd = 1'b0;
        avl.ddr3_avl_ready = 1'b1;
        tick;
        for (int i = 1; i <= 40 && k < 0; i++) begin
            tick;
            if (test_rd_err) k = i;
        end
        total++;
        if (k != TO) $display("FAIL timeout_latency: err after %0d cycles required %0d", k, TO);
        else passed++;
        total++;
        if ({test_busy, avl.ddr3_avl_read_req, test_rd_data} !== {2'b00, prev})
            $display("FAIL timeout_state: busy=%b req=%b data=%h required 0/0/%h", test_busy, avl.ddr3_avl_read_req, test_rd_data, prev);
        else passed++;
        tick;
        total++;
        if ({test_rd_err, 32'(done_cnt - dc0)} !== {1'b0, 32'd0})
            $display("FAIL timeout_pulse: err=%b done delta=%0d required 0/0", test_rd_err, done_cnt - dc0);
        else passed++;
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_gapped;
        test_busy_stray;
        test_reset_mid;
`ifdef READ_FROM_DDR3_TIMEOUT_EN
        test_timeout;
`else
        total++;
        if (err_cnt != 0) $display("FAIL err_tied_low: %0d err pulses required 0", err_cnt);
        else passed++;
`endif
        total++;
        if (exp_data_q.size() != 0) $display("FAIL missing_beats: %0d beats outstanding required 0", exp_data_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
